cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL provide parameter RST_CYCLES, default 4, number of clk cycles rst_cpu is held after rst deasserts (legal range 1..255).
REQ-002 SHALL provide port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port run_sw  input  1  level; 1 = free-run the CPU.
REQ-005 SHALL provide port step_btn  input  1  debounced, clk-synchronous; each rising edge requests one CPU step.
REQ-006 SHALL provide port halt_req  input  1  level from CPU; 1 = stop issuing enables.
REQ-007 SHALL provide port div_ratio  input  8  run-mode period minus one; cpu_en period = div_ratio+1 clk cycles.
REQ-008 SHALL provide port cpu_en  output  1  registered one-cycle CPU advance enable.
REQ-009 SHALL provide port rst_cpu  output  1  registered CPU reset.
REQ-010 SHALL provide port running  output  1  registered; 1 while state is RUN.
REQ-011 SHALL provide port cycle_cnt  output  32  registered count of cpu_en pulses issued.

Function
REQ-012 SHALL implement FSM states RST_HOLD, HALT, RUN, STEP; running = (state==RUN).
REQ-013 SHALL detect step rise = step_btn & ~step_q, where step_q is step_btn registered.
REQ-014 RST_HOLD: rst_cpu=1, cpu_en=0; hold counter increments each cycle; at the edge where the counter reaches RST_CYCLES-1, state<=HALT and rst_cpu<=0, so rst_cpu stays high exactly RST_CYCLES cycles after rst falls.
REQ-015 HALT: cpu_en=0, divider cnt=0; if run_sw & ~halt_req -> RUN; else if rise & ~halt_req -> STEP; else stay.
REQ-016 HALT, run_sw and step rise in the same cycle: run SHALL win; the step is discarded.
REQ-017 STEP: at the next edge, cpu_en<=1 for exactly one cycle and state<=HALT, regardless of run_sw/halt_req in that cycle.
REQ-018 RUN: 8-bit divider cnt; at each edge, if run_sw=0 or halt_req=1 -> HALT, cnt<=0, cpu_en<=0 (halt beats terminal count); else if cnt>=div_ratio -> cpu_en<=1, cnt<=0; else cpu_en<=0, cnt<=cnt+1.
REQ-019 Using >= SHALL make a div_ratio decrease below the current cnt fire on the next edge (no 256-cycle wrap).
REQ-020 div_ratio=0 SHALL yield cpu_en high every cycle in RUN starting one edge after RUN entry.
REQ-021 RUN latency: run_sw sampled at edge k (HALT->RUN) -> first cpu_en high after edge k+1+div_ratio, then every div_ratio+1 cycles.
REQ-022 step rises while in RUN or STEP SHALL be ignored (not queued).
REQ-023 cycle_cnt SHALL increment by 1 on each edge that sets cpu_en<=1, wrapping 0xFFFFFFFF->0x00000000.
REQ-024 halt_req raised while in STEP SHALL not cancel the pending pulse.

Reset
REQ-025 rst=1 at an edge SHALL, from any state, force: state=RST_HOLD, hold counter=0, rst_cpu=1, cpu_en=0, running=0, cnt=0, cycle_cnt=0, step_q=0.
REQ-026 rst held high SHALL keep the hold counter at 0; counting starts on the first edge with rst=0.
REQ-027 step_btn held high across reset release SHALL produce a rise only if it went low-then-high after reset release... and since step_q resets to 0, a high step_btn at release SHALL be registered as a rise only once state is HALT; any rise detected in RST_HOLD is discarded.

Verification
REQ-028 rst 1 for 3 cycles then 0, RST_CYCLES=4 -> rst_cpu high 4 cycles after rst falls, then 0; cpu_en=0, cycle_cnt=0 throughout.
REQ-029 HALT, div_ratio=3, run_sw=1 sampled at edge 0 -> cpu_en high after edges 4, 8, 12; cycle_cnt=3 after edge 12; running=1.
REQ-030 RUN, div_ratio=0 -> cpu_en continuous; halt_req=1 at edge n -> cpu_en=0 after edge n, state HALT, cycle_cnt frozen.
REQ-031 HALT, step_btn 0->1 held 10 cycles -> exactly one cpu_en pulse, 2 edges after the rise; cycle_cnt +1; second press yields second pulse.
REQ-032 RUN, div_ratio=200, cnt=150, div_ratio changed to 10 -> cpu_en on next edge, then period 11.
REQ-033 RUN with cycle_cnt=0xFFFFFFFF preloaded via force -> next pulse gives 0x00000000; rst mid-RUN -> all outputs to reset values on that edge.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// CPU run/step/halt controller: holds the CPU in reset after system reset, then
// issues single-cycle advance enables either free-running at a divided rate or one per step press.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        halt_req,
  input  logic [7:0]  div_ratio,
  output logic        cpu_en,
  output logic        rst_cpu,
  output logic        running,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {RST_HOLD, HALT, RUN, STEP} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        step_q;
  logic        step_rise;
  logic        cpu_en_q, cpu_en_d;
  logic        rst_cpu_q;
  logic        running_q;
  logic [31:0] cycle_q, cycle_d;

  assign step_rise = step_btn & ~step_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    div_cnt_d = div_cnt_q;
    cpu_en_d  = 1'b0;
    unique case (state_q)
      RST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = HALT;
          hold_d  = 8'd0;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      HALT: begin
        div_cnt_d = 8'd0;
        // Run has priority over a coincident step press, which is dropped.
        if (run_sw && !halt_req)         state_d = RUN;
        else if (step_rise && !halt_req) state_d = STEP;
      end
      STEP: begin
        cpu_en_d = 1'b1;
        state_d  = HALT;
      end
      RUN: begin
        // >= rather than == so lowering div_ratio below the count fires at once.
        if (!run_sw || halt_req) begin
          state_d   = HALT;
          div_cnt_d = 8'd0;
        end else if (div_cnt_q >= div_ratio) begin
          cpu_en_d  = 1'b1;
          div_cnt_d = 8'd0;
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: state_d = RST_HOLD;
    endcase
    cycle_d = cycle_q + {31'd0, cpu_en_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_HOLD;
      hold_q    <= 8'd0;
      div_cnt_q <= 8'd0;
      step_q    <= 1'b0;
      cpu_en_q  <= 1'b0;
      rst_cpu_q <= 1'b1;
      running_q <= 1'b0;
      cycle_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      div_cnt_q <= div_cnt_d;
      step_q    <= step_btn;
      cpu_en_q  <= cpu_en_d;
      rst_cpu_q <= (state_d == RST_HOLD);
      running_q <= (state_d == RUN);
      cycle_q   <= cycle_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign rst_cpu   = rst_cpu_q;
  assign running   = running_q;
  assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus randomized traffic, all compared
// every cycle against a behavioural model of the run/step/halt rules.
module tb_cpu_run_ctrl;

  localparam int unsigned RST_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst, run_sw, step_btn, halt_req;
  logic [7:0]  div_ratio;
  logic        cpu_en, rst_cpu, running;
  logic [31:0] cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_in_hold, m_run, m_step_pend, m_prev_step;
  int          m_hold_elapsed, m_phase;
  bit          m_cpu_en, m_rst_cpu, m_running;
  logic [31:0] m_cycle;

  cpu_run_ctrl #(.RST_CYCLES(RST_CYCLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .halt_req  (halt_req),
    .div_ratio (div_ratio),
    .cpu_en    (cpu_en),
    .rst_cpu   (rst_cpu),
    .running   (running),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One rising edge of the model, using the inputs the DUT sampled at that edge.
  task automatic model_edge();
    bit rise, pulse;
    if (rst) begin
      m_in_hold = 1; m_hold_elapsed = 0; m_run = 0; m_step_pend = 0;
      m_prev_step = 0; m_phase = 0;
      m_cpu_en = 0; m_rst_cpu = 1; m_running = 0; m_cycle = 0;
      return;
    end
    rise = step_btn && !m_prev_step;
    m_prev_step = step_btn;
    pulse = 0;
    if (m_in_hold) begin
      m_hold_elapsed++;
      if (m_hold_elapsed == int'(RST_CYCLES)) m_in_hold = 0;
    end else if (m_step_pend) begin
      pulse = 1;
      m_step_pend = 0;
    end else if (m_run) begin
      if (!run_sw || halt_req) m_run = 0;
      else if (m_phase >= int'(div_ratio)) begin pulse = 1; m_phase = 0; end
      else m_phase++;
    end else begin
      if (run_sw && !halt_req) begin m_run = 1; m_phase = 0; end
      else if (rise && !halt_req) m_step_pend = 1;
    end
    m_cpu_en  = pulse;
    m_cycle   = m_cycle + (pulse ? 32'd1 : 32'd0);
    m_rst_cpu = m_in_hold;
    m_running = m_run;
  endtask

  // Inputs are driven at the falling edge; outputs sampled at the next falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cpu_en",    {31'd0, cpu_en},  {31'd0, m_cpu_en});
    check("rst_cpu",   {31'd0, rst_cpu}, {31'd0, m_rst_cpu});
    check("running",   {31'd0, running}, {31'd0, m_running});
    check("cycle_cnt", cycle_cnt,        m_cycle);
  endtask

  int n_hi, n_pulse, pulse_at;
  logic [31:0] base;

  initial begin
    rst = 1; run_sw = 0; step_btn = 0; halt_req = 0; div_ratio = 8'd0;
    @(negedge clk);

    // Reset hold: three reset cycles, then rst_cpu stays high RST_CYCLES cycles.
    repeat (3) tick();
    check("rst_cpu_in_reset", {31'd0, rst_cpu}, 32'd1);
    check("cpu_en_in_reset",  {31'd0, cpu_en},  32'd0);
    check("cycle_in_reset",   cycle_cnt,        32'd0);
    rst = 0;
    n_hi = 0;
    repeat (8) begin
      if (rst_cpu) n_hi++;
      tick();
    end
    check("rst_cpu_hold_len", n_hi, RST_CYCLES);
    check("cycle_after_hold", cycle_cnt, 32'd0);

    // Free run at div_ratio=3: pulses after edges 4, 8, 12.
    div_ratio = 8'd3; run_sw = 1;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 11) check("run_no_pulse_e11", {31'd0, cpu_en}, 32'd0);
      run_sw = 1;
    end
    check("run_pulse_e12", {31'd0, cpu_en}, 32'd1);
    check("run_cycle_3",   cycle_cnt, 32'd3);
    check("running_high",  {31'd0, running}, 32'd1);

    // div_ratio=0 continuous, then halt_req freezes the count.
    div_ratio = 8'd0;
    repeat (6) tick();
    check("div0_cont", {31'd0, cpu_en}, 32'd1);
    base = m_cycle;
    halt_req = 1;
    tick();
    check("halt_cpu_en",  {31'd0, cpu_en},  32'd0);
    check("halt_running", {31'd0, running}, 32'd0);
    repeat (4) tick();
    check("halt_frozen", cycle_cnt, base);

    // Step: held press gives exactly one pulse, on the second edge after the rise.
    run_sw = 0; halt_req = 0;
    repeat (2) tick();
    base = m_cycle;
    step_btn = 1; n_pulse = 0; pulse_at = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_en) begin n_pulse++; pulse_at = i; end
    end
    check("step_one_pulse", n_pulse, 32'd1);
    check("step_latency",   pulse_at, 32'd1);
    check("step_cycle_inc", cycle_cnt, base + 32'd1);
    step_btn = 0; tick();
    step_btn = 1; n_pulse = 0;
    repeat (4) begin tick(); if (cpu_en) n_pulse++; end
    check("step_second", n_pulse, 32'd1);
    step_btn = 0;

    // Lowering div_ratio below the current count fires on the next edge.
    div_ratio = 8'd200; run_sw = 1;
    repeat (151) tick();
    check("slow_no_pulse", cycle_cnt, base + 32'd2);
    div_ratio = 8'd10;
    tick();
    check("ratio_drop_fire", {31'd0, cpu_en}, 32'd1);
    n_pulse = 0;
    repeat (10) begin tick(); if (cpu_en) n_pulse++; end
    check("ratio_gap", n_pulse, 32'd0);
    tick();
    check("ratio_period11", {31'd0, cpu_en}, 32'd1);

    // Counter wrap via preload, then reset mid-run.
    div_ratio = 8'd0;
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFF;
    tick();
    check("cycle_wrap", cycle_cnt, 32'd0);
    rst = 1;
    tick();
    check("midrun_rst_en",   {31'd0, cpu_en},  32'd0);
    check("midrun_rst_run",  {31'd0, running}, 32'd0);
    check("midrun_rst_rcpu", {31'd0, rst_cpu}, 32'd1);
    check("midrun_rst_cnt",  cycle_cnt, 32'd0);
    rst = 0; run_sw = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 29) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 3) == 0)  step_btn = ~step_btn;
      if ($urandom_range(0, 49) == 0) div_ratio = 8'($urandom_range(0, 12));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
